// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks EX/MEM/WB writers and produces stall, flush,
// forwarding selects and saturating stall/flush statistics for a 5-stage core.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int ZERO_REG   = 31,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
   input  logic [NUM_SRC-1:0]            id_src_used,
   input  logic [REG_ADDR_W-1:0]         id_dst,
   input  logic                          id_wr,
   input  logic                          id_load,
   input  logic                          id_store,
   input  logic                          branch_taken,
   input  logic                          mem_ready,
   output logic                          pc_write,
   output logic                          if_id_write,
   output logic                          ctrl_bubble,
   output logic                          if_flush,
   output logic                          id_flush,
   output logic                          ex_flush,
   output logic                          mem_stall,
   output logic [2*NUM_SRC-1:0]          fwd_sel,
   output logic [CNT_W-1:0]              stall_cnt,
   output logic [CNT_W-1:0]              flush_cnt
);

   localparam logic [REG_ADDR_W-1:0] XZR = REG_ADDR_W'(ZERO_REG);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic src_hit(input logic vld, input logic wr,
                                    input logic [REG_ADDR_W-1:0] dst,
                                    input logic [REG_ADDR_W-1:0] src,
                                    input logic used);
      return vld && wr && used && (dst == src) && (src != XZR);
   endfunction

   logic                          ex_valid_q, ex_valid_d, ex_wr_q, ex_wr_d;
   logic                          ex_load_q, ex_load_d, ex_mem_op_q, ex_mem_op_d;
   logic [REG_ADDR_W-1:0]         ex_dst_q, ex_dst_d;
   logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_q, ex_src_d;
   logic [NUM_SRC-1:0]            ex_src_used_q, ex_src_used_d;
   logic                          mem_valid_q, mem_valid_d, mem_wr_q, mem_wr_d;
   logic                          mem_load_q, mem_load_d, mem_mem_op_q, mem_mem_op_d;
   logic [REG_ADDR_W-1:0]         mem_dst_q, mem_dst_d;
   logic                          wb_valid_q, wb_valid_d, wb_wr_q, wb_wr_d;
   logic [REG_ADDR_W-1:0]         wb_dst_q, wb_dst_d;
   logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic                          hz_stall, flush, stall;

   // Without forwarding every in-flight writer ahead of WB blocks the reader;
   // with forwarding only a load still in EX cannot supply its data in time.
   always_comb begin
      hz_stall = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_hit(ex_valid_q, ex_wr_q, ex_dst_q, id_src[i*REG_ADDR_W +: REG_ADDR_W],
                     id_src_used[i]) && (FWD_EN == 0 || ex_load_q))
            hz_stall = 1'b1;
         if (FWD_EN == 0 && src_hit(mem_valid_q, mem_wr_q, mem_dst_q,
                                    id_src[i*REG_ADDR_W +: REG_ADDR_W], id_src_used[i]))
            hz_stall = 1'b1;
      end
      hz_stall = hz_stall & id_valid;
   end

   assign mem_stall   = mem_valid_q & mem_mem_op_q & ~mem_ready;
   assign flush       = branch_taken & ~mem_stall;
   assign stall       = hz_stall & ~flush & ~mem_stall;
   assign pc_write    = ~mem_stall & ~stall;
   assign if_id_write = ~mem_stall & ~stall;
   assign ctrl_bubble = stall;
   assign if_flush    = flush;
   assign id_flush    = flush;
   assign ex_flush    = flush;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

   // A load in MEM has no ALU result to forward; the load-use stall keeps
   // that case from reaching EX, so it simply falls back to the regfile.
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (FWD_EN != 0) begin
            if (src_hit(mem_valid_q, mem_wr_q, mem_dst_q, ex_src_q[i*REG_ADDR_W +: REG_ADDR_W],
                        ex_src_used_q[i] & ex_valid_q))
               fwd_sel[2*i +: 2] = mem_load_q ? 2'b00 : 2'b10;
            else if (src_hit(wb_valid_q, wb_wr_q, wb_dst_q, ex_src_q[i*REG_ADDR_W +: REG_ADDR_W],
                             ex_src_used_q[i] & ex_valid_q))
               fwd_sel[2*i +: 2] = 2'b01;
         end
      end
   end

   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_wr_d       = ex_wr_q;
      ex_load_d     = ex_load_q;
      ex_mem_op_d   = ex_mem_op_q;
      ex_dst_d      = ex_dst_q;
      ex_src_d      = ex_src_q;
      ex_src_used_d = ex_src_used_q;
      mem_valid_d   = mem_valid_q;
      mem_wr_d      = mem_wr_q;
      mem_load_d    = mem_load_q;
      mem_mem_op_d  = mem_mem_op_q;
      mem_dst_d     = mem_dst_q;
      if (!mem_stall) begin
         mem_valid_d   = ex_valid_q & ~flush;
         mem_wr_d      = ex_wr_q;
         mem_load_d    = ex_load_q;
         mem_mem_op_d  = ex_mem_op_q;
         mem_dst_d     = ex_dst_q;
         ex_valid_d    = id_valid & ~flush & ~hz_stall;
         ex_wr_d       = id_wr;
         ex_load_d     = id_load;
         ex_mem_op_d   = id_load | id_store;
         ex_dst_d      = id_dst;
         ex_src_d      = id_src;
         ex_src_used_d = id_src_used;
      end
      // WB drains while MEM waits on memory, so it sees a bubble.
      wb_valid_d  = mem_valid_q & ~mem_stall;
      wb_wr_d     = mem_wr_q;
      wb_dst_d    = mem_dst_q;
      stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         wb_valid_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         mem_valid_q <= mem_valid_d;
         wb_valid_q  <= wb_valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      ex_wr_q       <= ex_wr_d;
      ex_load_q     <= ex_load_d;
      ex_mem_op_q   <= ex_mem_op_d;
      ex_dst_q      <= ex_dst_d;
      ex_src_q      <= ex_src_d;
      ex_src_used_q <= ex_src_used_d;
      mem_wr_q      <= mem_wr_d;
      mem_load_q    <= mem_load_d;
      mem_mem_op_q  <= mem_mem_op_d;
      mem_dst_q     <= mem_dst_d;
      wb_wr_q       <= wb_wr_d;
      wb_dst_q      <= wb_dst_d;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a forwarding instance (default parameters)
// and a stall-only instance with a 2-bit counter to reach saturation.
module tb_hazard_scoreboard;
   localparam int AW = 5;
   localparam int NS = 2;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   logic           id_valid, id_wr, id_load, id_store, branch_taken, mem_ready;
   logic [NS*AW-1:0] id_src;
   logic [NS-1:0]  id_src_used;
   logic [AW-1:0]  id_dst;
   logic           pc_write, if_id_write, ctrl_bubble, if_flush, id_flush, ex_flush, mem_stall;
   logic [2*NS-1:0] fwd0;
   logic [15:0]    stall_cnt, flush_cnt;

   logic           b_valid, b_wr, b_load, b_store, b_branch, b_ready;
   logic [NS*AW-1:0] b_src;
   logic [NS-1:0]  b_used;
   logic [AW-1:0]  b_dst;
   logic           b_pcw, b_ifidw, b_bubble, b_iff, b_idf, b_exf, b_mstall;
   logic [2*NS-1:0] fwd1;
   logic [1:0]     b_stall_cnt, b_flush_cnt;

   logic [6:0] ctl0, ctl1;
   assign ctl0 = {pc_write, if_id_write, ctrl_bubble, if_flush, id_flush, ex_flush, mem_stall};
   assign ctl1 = {b_pcw, b_ifidw, b_bubble, b_iff, b_idf, b_exf, b_mstall};

   always #5 clk = ~clk;

   hazard_scoreboard u_fwd (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
      .id_store(id_store), .branch_taken(branch_taken), .mem_ready(mem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write), .ctrl_bubble(ctrl_bubble),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_stall(mem_stall),
      .fwd_sel(fwd0), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) u_nofwd (
      .clk(clk), .reset(reset), .id_valid(b_valid), .id_src(b_src),
      .id_src_used(b_used), .id_dst(b_dst), .id_wr(b_wr), .id_load(b_load),
      .id_store(b_store), .branch_taken(b_branch), .mem_ready(b_ready),
      .pc_write(b_pcw), .if_id_write(b_ifidw), .ctrl_bubble(b_bubble),
      .if_flush(b_iff), .id_flush(b_idf), .ex_flush(b_exf), .mem_stall(b_mstall),
      .fwd_sel(fwd1), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input int s0, input int s1, input logic [1:0] used,
                         input int dst, input logic wr, input logic ld, input logic st);
      id_valid    = v;
      id_src      = {AW'(s1), AW'(s0)};
      id_src_used = used;
      id_dst      = AW'(dst);
      id_wr       = wr;
      id_load     = ld;
      id_store    = st;
   endtask

   task automatic set_b(input logic v, input int s0, input logic [1:0] used,
                        input int dst, input logic wr);
      b_valid = v;
      b_src   = {AW'(0), AW'(s0)};
      b_used  = used;
      b_dst   = AW'(dst);
      b_wr    = wr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      set_b(1'b0, 0, 2'b00, 0, 1'b0);
      b_load = 1'b0; b_store = 1'b0; b_branch = 1'b0; b_ready = 1'b1;
      branch_taken = 1'b0;
      mem_ready    = 1'b1;
      #1 reset = 1'b0;
      #1;
      chk("rst_ctl", 32'(ctl0), 32'b1100000);
      chk("rst_fwd", 32'(fwd0), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      chk("rst_flush_cnt", 32'(flush_cnt), 0);
      chk("rst_ctl_nofwd", 32'(ctl1), 32'b1100000);
      #1 reset = 1'b1;
      tick();

      // load-use: LDUR X2 then ADD X3,X2,X4
      set_id(1'b1, 9, 0, 2'b01, 2, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 2, 4, 2'b11, 3, 1'b1, 1'b0, 1'b0);
      #1 chk("lu_stall_ctl", 32'(ctl0), 32'b0010000);
      tick();
      #1 chk("lu_resume_ctl", 32'(ctl0), 32'b1100000);
      chk("lu_stall_cnt", 32'(stall_cnt), 1);
      tick();
      idle();
      #1 chk("lu_fwd_wb", 32'(fwd0), 32'b0001);
      tick(); tick(); tick();

      // MEM priority over WB; src1 unused must not forward
      set_id(1'b1, 0, 0, 2'b00, 1, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      set_id(1'b1, 1, 1, 2'b01, 7, 1'b1, 1'b0, 1'b0);
      #1 chk("prio_no_stall", 32'(ctl0), 32'b1100000);
      tick();
      idle();
      #1 chk("prio_fwd_mem", 32'(fwd0), 32'b0010);
      tick(); tick(); tick();

      // load to XZR is never a hazard
      set_id(1'b1, 0, 0, 2'b00, 31, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 31, 31, 2'b11, 8, 1'b1, 1'b0, 1'b0);
      #1 chk("xzr_no_stall", 32'(ctl0), 32'b1100000);
      tick();
      idle();
      #1 chk("xzr_fwd", 32'(fwd0), 0);
      chk("xzr_stall_cnt", 32'(stall_cnt), 1);
      tick(); tick(); tick();

      // branch during load-use: flush wins
      set_id(1'b1, 9, 0, 2'b01, 2, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 2, 4, 2'b11, 3, 1'b1, 1'b0, 1'b0);
      branch_taken = 1'b1;
      #1 chk("br_flush_ctl", 32'(ctl0), 32'b1101110);
      tick();
      branch_taken = 1'b0;
      mem_ready    = 1'b0;
      #1 chk("br_after_ctl", 32'(ctl0), 32'b1100000);
      chk("br_flush_cnt", 32'(flush_cnt), 1);
      chk("br_stall_cnt", 32'(stall_cnt), 1);
      mem_ready = 1'b1;
      idle();
      tick(); tick();

      // memory wait with LDUR X2 in MEM and LDUR X9 in EX
      set_id(1'b1, 9, 0, 2'b01, 2, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 0, 0, 2'b00, 9, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 9, 0, 2'b01, 10, 1'b1, 1'b0, 1'b0);
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         branch_taken = (k == 1);
         #1 chk("ms_ctl", 32'(ctl0), 32'b0000001);
         chk("ms_stall_cnt", 32'(stall_cnt), 1);
         tick();
      end
      branch_taken = 1'b0;
      mem_ready    = 1'b1;
      #1 chk("ms_ex_held_ctl", 32'(ctl0), 32'b0010000);
      chk("ms_flush_cnt", 32'(flush_cnt), 1);
      tick();
      #1 chk("ms_resume_ctl", 32'(ctl0), 32'b1100000);
      chk("ms_stall_cnt2", 32'(stall_cnt), 2);
      tick();
      idle();
      #1 chk("ms_fwd_wb", 32'(fwd0), 32'b0001);
      tick(); tick(); tick();

      // asynchronous reset in the middle of a load-use stall
      set_id(1'b1, 9, 0, 2'b01, 2, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 2, 4, 2'b11, 3, 1'b1, 1'b0, 1'b0);
      #1 chk("rs_pre_ctl", 32'(ctl0), 32'b0010000);
      #1 reset = 1'b0;
      #1 chk("rs_ctl", 32'(ctl0), 32'b1100000);
      chk("rs_stall_cnt", 32'(stall_cnt), 0);
      chk("rs_flush_cnt", 32'(flush_cnt), 0);
      tick();
      reset = 1'b1;
      #1 chk("rs_post_ctl", 32'(ctl0), 32'b1100000);
      tick();
      #1 chk("rs_post_cnt", 32'(stall_cnt), 0);
      idle();
      tick(); tick();

      // stall-only instance: RAW on EX and MEM, WB free, counter saturates at 3
      set_b(1'b1, 0, 2'b00, 5, 1'b1);
      tick();
      set_b(1'b1, 5, 2'b01, 5, 1'b1);
      #1 chk("nf_ex_raw", 32'(ctl1), 32'b0010000);
      tick();
      #1 chk("nf_mem_raw", 32'(ctl1), 32'b0010000);
      chk("nf_fwd_off", 32'(fwd1), 0);
      tick();
      #1 chk("nf_wb_free", 32'(ctl1), 32'b1100000);
      chk("nf_cnt2", 32'(b_stall_cnt), 2);
      tick();
      #1 chk("nf_ex_raw2", 32'(ctl1), 32'b0010000);
      tick();
      #1 chk("nf_mem_raw2", 32'(ctl1), 32'b0010000);
      chk("nf_cnt3", 32'(b_stall_cnt), 3);
      tick();
      #1 chk("nf_cnt_sat", 32'(b_stall_cnt), 3);
      chk("nf_free2", 32'(ctl1), 32'b1100000);
      chk("nf_fwd_zero", 32'(fwd1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
